// File: rtl/mul_stage_2503.sv
// mul_stage_2503: two-stage elastic 12x12 multiplier feeding the mod-2503 reducer.
// Optional operand range correction: define MUL_STAGE_2503_RANGECHK_EN.
module mul_stage_2503 #(
  parameter int Q  = 2503,
  parameter int AW = 12,
  parameter int PW = 23
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] din_a,
  input  logic [AW-1:0] din_b,
  input  logic          din_valid,
  output logic          din_ready,
  output logic [PW-1:0] dout_p,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          dout_err,
  output logic          busy
);

`ifdef MUL_STAGE_2503_RANGECHK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  localparam logic [AW-1:0] QV = AW'(Q);

  logic          s1_v;
  logic          s1_err;
  logic [AW-1:0] s1_a;
  logic [AW-1:0] s1_b;
  logic          s2_v;
  logic          s2_err;
  logic [PW-1:0] s2_p;

  logic          s1_adv;
  logic          s2_adv;
  logic          a_hi;
  logic          b_hi;
  logic [AW-1:0] a_ld;
  logic [AW-1:0] b_ld;
  logic          err_ld;
  logic [PW-1:0] prod;

  // Elastic advance: a stage moves when it is empty or its consumer moves.
  assign s2_adv    = !s2_v || dout_ready;
  assign s1_adv    = !s1_v || s2_adv;
  assign din_ready = s1_adv;

  // One subtract folds any 12-bit value into range; off unless enabled.
  assign a_hi   = RC && (din_a >= QV);
  assign b_hi   = RC && (din_b >= QV);
  assign a_ld   = a_hi ? din_a - QV : din_a;
  assign b_ld   = b_hi ? din_b - QV : din_b;
  assign err_ld = a_hi || b_hi;

  // Zero-extend before multiplying so no product bits are lost.
  assign prod = {{(PW-AW){1'b0}}, s1_a} * {{(PW-AW){1'b0}}, s1_b};

  // Operand stage: capture the incoming pair whenever S1 may advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v   <= 1'b0;
      s1_err <= 1'b0;
      s1_a   <= '0;
      s1_b   <= '0;
    end else if (s1_adv) begin
      s1_v   <= din_valid;
      s1_err <= err_ld;
      s1_a   <= a_ld;
      s1_b   <= b_ld;
    end
  end

  // Product stage: holds its word stable while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v   <= 1'b0;
      s2_err <= 1'b0;
      s2_p   <= '0;
    end else if (s2_adv) begin
      s2_v   <= s1_v;
      s2_err <= s1_err;
      s2_p   <= prod;
    end
  end

  assign dout_p     = s2_p;
  assign dout_valid = s2_v;
  assign dout_err   = s2_err;
  assign busy       = s1_v || s2_v;

endmodule

// File: tb/tb_mul_stage_2503.sv
// tb_mul_stage_2503: directed checks of the mod-2503 product stage.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_mul_stage_2503;

  logic        clk;
  logic        rst;
  logic [11:0] din_a;
  logic [11:0] din_b;
  logic        din_valid;
  logic        din_ready;
  logic [22:0] dout_p;
  logic        dout_valid;
  logic        dout_ready;
  logic        dout_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mul_stage_2503 dut (
    .clk        (clk),
    .rst        (rst),
    .din_a      (din_a),
    .din_b      (din_b),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout_p     (dout_p),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_err   (dout_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int recv;
    int low;
    logic hold_v;
    logic [22:0] hold_p;

    rst = 1'b1;
    din_a = '0;
    din_b = '0;
    din_valid = 1'b0;
    dout_ready = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_valid", dout_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", dout_err, 0);
    chk("rst_p", dout_p, 0);
    chk("rst_ready", din_ready, 1);
    rst = 1'b0;
    nxt();

    // Single max pair, latency 2
    din_valid = 1'b1;
    din_a = 12'd2502;
    din_b = 12'd2502;
    @(negedge clk);
    chk("t1_rdy", din_ready, 1);
    nxt();
    din_valid = 1'b0;
    @(negedge clk);
    chk("t1_v_n1", dout_valid, 0);
    chk("t1_busy", busy, 1);
    nxt();
    @(negedge clk);
    chk("t1_v_n2", dout_valid, 1);
    chk("t1_p", dout_p, 6260004);
    chk("t1_err", dout_err, 0);
    nxt();
    @(negedge clk);
    chk("t1_v_n3", dout_valid, 0);
    chk("t1_idle", busy, 0);
    nxt();

    // Back-to-back stream, full throughput
    for (int c = 0; c < 10; c++) begin
      din_valid = (c < 8);
      din_a = 12'(c);
      din_b = 12'(c + 1);
      @(negedge clk);
      chk("t2_rdy", din_ready, 1);
      if (c >= 2) begin
        chk("t2_v", dout_valid, 1);
        chk("t2_p", dout_p, 32'((c - 2) * (c - 1)));
      end
      nxt();
    end
    din_valid = 1'b0;
    @(negedge clk);
    chk("t2_end_v", dout_valid, 0);
    nxt();

    // Stream with downstream stall in cycles 3..6
    sent = 0;
    recv = 0;
    low = 0;
    hold_v = 1'b0;
    hold_p = '0;
    for (int c = 0; c < 40 && recv < 8; c++) begin
      dout_ready = !(c >= 3 && c <= 6);
      din_valid = (sent < 8);
      din_a = 12'(sent);
      din_b = 12'(sent + 1);
      @(negedge clk);
      chk("t3_rdy", din_ready, !((sent - recv) == 2 && !dout_ready));
      if (!din_ready) low++;
      if (hold_v) begin
        chk("t3_hold_v", dout_valid, 1);
        chk("t3_hold_p", dout_p, hold_p);
      end
      if (dout_valid && dout_ready) begin
        chk("t3_order", dout_p, 32'(recv * (recv + 1)));
        recv++;
      end
      hold_v = dout_valid && !dout_ready;
      hold_p = dout_p;
      if (din_valid && din_ready) sent++;
      nxt();
    end
    chk("t3_count", recv, 8);
    chk("t3_fell", low > 0, 1);
    din_valid = 1'b0;
    dout_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t3_nodup", dout_valid, 0);
      nxt();
    end

    // Async reset with two pairs in flight
    dout_ready = 1'b0;
    din_valid = 1'b1;
    din_a = 12'd5;
    din_b = 12'd6;
    @(negedge clk);
    nxt();
    din_a = 12'd7;
    din_b = 12'd8;
    @(negedge clk);
    nxt();
    din_valid = 1'b0;
    @(negedge clk);
    chk("t4_full_v", dout_valid, 1);
    chk("t4_full_rdy", din_ready, 0);
    chk("t4_full_p", dout_p, 30);
    #2;
    rst = 1'b1;
    #1;
    chk("t4_v", dout_valid, 0);
    chk("t4_busy", busy, 0);
    chk("t4_err", dout_err, 0);
    chk("t4_rdy", din_ready, 1);
    chk("t4_p", dout_p, 0);
    dout_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      nxt();
      @(negedge clk);
      chk("t4_stale", dout_valid, 0);
      chk("t4_idle", busy, 0);
    end
    nxt();

    // Out-of-range operand then a legal one
    din_valid = 1'b1;
    din_a = 12'd3000;
    din_b = 12'd2;
    @(negedge clk);
    chk("t5_rdy0", din_ready, 1);
    nxt();
    din_a = 12'd2502;
    din_b = 12'd1;
    @(negedge clk);
    chk("t5_rdy1", din_ready, 1);
    nxt();
    din_valid = 1'b0;
    @(negedge clk);
    chk("t5_v0", dout_valid, 1);
`ifdef MUL_STAGE_2503_RANGECHK_EN
    chk("t5_p0", dout_p, 994);
    chk("t5_err0", dout_err, 1);
`else
    chk("t5_err0", dout_err, 0);
`endif
    nxt();
    @(negedge clk);
    chk("t5_v1", dout_valid, 1);
    chk("t5_p1", dout_p, 2502);
    chk("t5_err1", dout_err, 0);
    nxt();
    @(negedge clk);
    chk("t5_v2", dout_valid, 0);
    chk("t5_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
